// File: rtl/x_mem_arb_if.sv
// Bus bundle between the memory arbiter and its N requesters plus the shared memory port.
// Signal names are taken from the arbiter's point of view (i_ = into the arbiter).
interface x_mem_arb_if #(
    parameter int N = 2
);
    localparam int DATA_W = 32;

    logic [N-1:0]        i_req_valid;
    logic [N-1:0]        i_req_rnw;
    logic [N*DATA_W-1:0] i_req_addr;
    logic [N*DATA_W-1:0] i_req_data;
    logic [N-1:0]        o_req_accept;
    logic [DATA_W-1:0]   o_req_data;
    logic [N-1:0]        o_grant;
    logic                o_valid;
    logic                o_rnw;
    logic [DATA_W-1:0]   o_addr;
    logic [DATA_W-1:0]   o_data;
    logic                i_accept;
    logic [DATA_W-1:0]   i_data;

    modport slave (
        input  i_req_valid, i_req_rnw, i_req_addr, i_req_data, i_accept, i_data,
        output o_req_accept, o_req_data, o_grant, o_valid, o_rnw, o_addr, o_data
    );

    modport master (
        output i_req_valid, i_req_rnw, i_req_addr, i_req_data, i_accept, i_data,
        input  o_req_accept, o_req_data, o_grant, o_valid, o_rnw, o_addr, o_data
    );
endinterface

// File: rtl/x_mem_arb.sv
// Round-robin arbiter sharing one single-port memory between N valid/accept requesters.
// A winner keeps the port until its request is accepted; grant is combinational.
module x_mem_arb #(
    parameter int N = 2
) (
    input logic       i_clk,
    input logic       i_nrst,
    x_mem_arb_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int IW     = $clog2(N);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] g;
    logic [IW+4:0] base;
    logic          present;
    logic [N-1:0]  grant_oh;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    endfunction

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        win_idx  = '0;
        scan_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            scan_idx = IW'((int'(ptr_q) + i) % N);
            if (bus.i_req_valid[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    assign g        = (state_q == OWNED) ? owner_q : win_idx;
    assign base     = {g, 5'd0};
    assign present  = i_nrst & bus.i_req_valid[g];
    assign grant_oh = present ? (N'(1) << g) : '0;

    assign bus.o_grant      = grant_oh;
    assign bus.o_valid      = present;
    assign bus.o_rnw        = present & bus.i_req_rnw[g];
    assign bus.o_addr       = present ? bus.i_req_addr[base +: DATA_W] : '0;
    assign bus.o_data       = present ? bus.i_req_data[base +: DATA_W] : '0;
    assign bus.o_req_accept = (present & bus.i_accept) ? grant_oh : '0;
    assign bus.o_req_data   = bus.i_data;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (present) begin
                    if (bus.i_accept) begin
                        ptr_d = next_idx(g);
                    end else begin
                        owner_d = g;
                        state_d = OWNED;
                    end
                end
            end
            OWNED: begin
                // A dropped owner valid releases the port without moving ptr.
                state_d = IDLE;
                if (present) begin
                    if (bus.i_accept) begin
                        ptr_d = next_idx(owner_q);
                    end else begin
                        state_d = OWNED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_x_mem_arb.sv
// Randomized and directed bench for x_mem_arb (N=2 and N=4 instances) against a rule-level model.
module tb_x_mem_arb;
    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    x_mem_arb_if #(.N(2)) b2 ();
    x_mem_arb_if #(.N(4)) b4 ();

    x_mem_arb #(.N(2)) dut2 (.i_clk(clk), .i_nrst(nrst), .bus(b2.slave));
    x_mem_arb #(.N(4)) dut4 (.i_clk(clk), .i_nrst(nrst), .bus(b4.slave));

    int errors = 0;
    int checks = 0;

    // Model state: priority pointer and locked owner (-1 = nobody holds the port).
    int m2_ptr = 0, m2_lock = -1;
    int m4_ptr = 0, m4_lock = -1;
    int g2, g4;
    bit p2, p4;
    logic [7:0] acc2, acc4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void pick(input int n, input int ptr, input int lock, input logic [7:0] v,
                                 output int g, output bit pres);
        g    = 0;
        pres = 1'b0;
        if (lock >= 0) begin
            g    = lock;
            pres = v[lock];
        end else begin
            for (int i = 0; i < n; i++) begin
                if (!pres && v[(ptr + i) % n]) begin
                    g    = (ptr + i) % n;
                    pres = 1'b1;
                end
            end
        end
    endfunction

    function automatic void advance(input int n, input int g, input bit pres, input logic acc,
                                    inout int ptr, inout int lock);
        if (pres && acc) begin
            ptr  = (g + 1) % n;
            lock = -1;
        end else if (pres) begin
            lock = g;
        end else begin
            lock = -1;
        end
    endfunction

    task automatic cmp(input string p, input int n, input int ptr, input int lock, input logic rst_off,
                       input logic [7:0] v, input logic [7:0] rnw, input logic [255:0] addr,
                       input logic [255:0] data, input logic acc, input logic [31:0] rdat,
                       input logic [7:0] o_gr, input logic [7:0] o_ac, input logic o_v,
                       input logic o_rnw, input logic [31:0] o_ad, input logic [31:0] o_da,
                       input logic [31:0] o_rd, output int g, output bit pres);
        logic [7:0] oh;
        pick(n, ptr, lock, v, g, pres);
        if (!rst_off) pres = 1'b0;
        oh = pres ? (8'd1 << g) : 8'd0;
        check({p, "grant"},  64'(o_gr),  64'(oh));
        check({p, "valid"},  64'(o_v),   64'(pres));
        check({p, "rnw"},    64'(o_rnw), pres ? 64'(rnw[g]) : 64'd0);
        check({p, "addr"},   64'(o_ad),  pres ? 64'(addr[32*g +: 32]) : 64'd0);
        check({p, "wdata"},  64'(o_da),  pres ? 64'(data[32*g +: 32]) : 64'd0);
        check({p, "accept"}, 64'(o_ac),  (pres && acc) ? 64'(oh) : 64'd0);
        check({p, "rdata"},  64'(o_rd),  64'(rdat));
    endtask

    task automatic settle();
        #4;
        cmp("n2.", 2, m2_ptr, m2_lock, nrst, 8'(b2.i_req_valid), 8'(b2.i_req_rnw),
            256'(b2.i_req_addr), 256'(b2.i_req_data), b2.i_accept, b2.i_data,
            8'(b2.o_grant), 8'(b2.o_req_accept), b2.o_valid, b2.o_rnw, b2.o_addr, b2.o_data,
            b2.o_req_data, g2, p2);
        cmp("n4.", 4, m4_ptr, m4_lock, nrst, 8'(b4.i_req_valid), 8'(b4.i_req_rnw),
            256'(b4.i_req_addr), 256'(b4.i_req_data), b4.i_accept, b4.i_data,
            8'(b4.o_grant), 8'(b4.o_req_accept), b4.o_valid, b4.o_rnw, b4.o_addr, b4.o_data,
            b4.o_req_data, g4, p4);
        acc2 = (p2 && b2.i_accept) ? (8'd1 << g2) : 8'd0;
        acc4 = (p4 && b4.i_accept) ? (8'd1 << g4) : 8'd0;
    endtask

    task automatic model_reset();
        m2_ptr = 0; m2_lock = -1;
        m4_ptr = 0; m4_lock = -1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (!nrst) begin
            model_reset();
        end else begin
            advance(2, g2, p2, b2.i_accept, m2_ptr, m2_lock);
            advance(4, g4, p4, b4.i_accept, m4_ptr, m4_lock);
        end
        #1;
    endtask

    task automatic step();
        settle();
        clk_edge();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b2.i_req_valid = 2'b11; b2.i_req_rnw = '0; b2.i_req_addr = '0; b2.i_req_data = '0;
        b2.i_accept = 1'b1; b2.i_data = 32'hA5A5_0001;
        b4.i_req_valid = '0; b4.i_req_rnw = '0; b4.i_req_addr = '0; b4.i_req_data = '0;
        b4.i_accept = 1'b0; b4.i_data = 32'h0;
        @(posedge clk); #1;
        step(); step();
        nrst = 1'b1;
        b2.i_req_valid = 2'b00;

        // Single read by requester 0, accepted immediately.
        b2.i_req_valid = 2'b01; b2.i_req_rnw = 2'b01; b2.i_req_addr[31:0] = 32'h100;
        b2.i_accept = 1'b1; b2.i_data = 32'hDEADBEEF;
        settle();
        check("single.addr", 64'(b2.o_addr), 64'h100);
        check("single.accept", 64'(b2.o_req_accept), 64'h1);
        check("single.rdata", 64'(b2.o_req_data), 64'hDEADBEEF);
        clk_edge();

        // Both requesting, memory accepts every cycle: grants alternate starting at ptr=1.
        b2.i_req_valid = 2'b11; b2.i_req_addr[63:32] = 32'h104;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("alt.grant", 64'(b2.o_grant), (i % 2 == 0) ? 64'h2 : 64'h1);
            check("alt.addr", 64'(b2.o_addr), (i % 2 == 0) ? 64'h104 : 64'h100);
            clk_edge();
        end

        // Requester 1 locks the port through a 3-cycle stall; requester 0 waits.
        b2.i_req_valid = 2'b10; b2.i_req_addr[63:32] = 32'h300;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) b2.i_req_valid[0] = 1'b1;
            b2.i_accept = (i == 3);
            settle();
            check("lock.grant", 64'(b2.o_grant), 64'h2);
            clk_edge();
        end
        b2.i_req_valid = 2'b01;
        settle();
        check("lock.after", 64'(b2.o_grant), 64'h1);
        clk_edge();
        b2.i_req_valid = 2'b00;

        // Write by requester 1 with two stall cycles.
        b2.i_req_valid = 2'b10; b2.i_req_rnw[1] = 1'b0;
        b2.i_req_addr[63:32] = 32'h200; b2.i_req_data[63:32] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            b2.i_accept = (i == 2);
            settle();
            check("wr.rnw", 64'(b2.o_rnw), 64'h0);
            check("wr.addr", 64'(b2.o_addr), 64'h200);
            check("wr.data", 64'(b2.o_data), 64'h12345678);
            check("wr.accept", 64'(b2.o_req_accept), (i == 2) ? 64'h2 : 64'h0);
            clk_edge();
        end

        // Owner drops valid while stalled: no request that cycle, ptr stays at 0.
        b2.i_req_valid = 2'b01; b2.i_accept = 1'b0;
        step();
        b2.i_req_valid = 2'b10; b2.i_accept = 1'b1;
        settle();
        check("drop.valid", 64'(b2.o_valid), 64'h0);
        check("drop.accept", 64'(b2.o_req_accept), 64'h0);
        clk_edge();
        b2.i_req_valid = 2'b11;
        settle();
        check("drop.ptr", 64'(b2.o_grant), 64'h1);
        clk_edge();

        // Reset asserted while requester 1 owns a stalled port.
        b2.i_req_valid = 2'b10; b2.i_accept = 1'b0;
        step();
        settle();
        nrst = 1'b0;
        model_reset();
        #1;
        check("rst.valid", 64'(b2.o_valid), 64'h0);
        check("rst.grant", 64'(b2.o_grant), 64'h0);
        clk_edge();
        step();
        nrst = 1'b1;
        b2.i_req_valid = 2'b11; b2.i_accept = 1'b1;
        settle();
        check("rst.ptr", 64'(b2.o_grant), 64'h1);
        clk_edge();
        b2.i_req_valid = 2'b00;

        // N=4 wrap: move ptr to 3, then 3 and 0 pending.
        b4.i_req_valid = 4'b0100; b4.i_accept = 1'b1;
        b4.i_req_addr[127:96] = 32'h3000; b4.i_req_addr[31:0] = 32'h0000;
        step();
        b4.i_req_valid = 4'b1001;
        settle();
        check("wrap.g3", 64'(b4.o_grant), 64'h8);
        check("wrap.addr3", 64'(b4.o_addr), 64'h3000);
        clk_edge();
        b4.i_req_valid = 4'b0001;
        settle();
        check("wrap.g0", 64'(b4.o_grant), 64'h1);
        clk_edge();
        b4.i_req_valid = 4'b0000;

        // Random traffic; requesters hold valid and fields until accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (acc2[k]) b2.i_req_valid[k] = 1'b0;
                if (!b2.i_req_valid[k] && $urandom_range(0, 9) < 4) begin
                    b2.i_req_valid[k] = 1'b1;
                    b2.i_req_rnw[k] = 1'($urandom);
                    b2.i_req_addr[32*k +: 32] = $urandom;
                    b2.i_req_data[32*k +: 32] = $urandom;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (acc4[k]) b4.i_req_valid[k] = 1'b0;
                if (!b4.i_req_valid[k] && $urandom_range(0, 9) < 4) begin
                    b4.i_req_valid[k] = 1'b1;
                    b4.i_req_rnw[k] = 1'($urandom);
                    b4.i_req_addr[32*k +: 32] = $urandom;
                    b4.i_req_data[32*k +: 32] = $urandom;
                end
            end
            b2.i_accept = 1'($urandom); b2.i_data = $urandom;
            b4.i_accept = 1'($urandom); b4.i_data = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
